// File: rtl/sent_tx_pulse_gen_p.sv
// SENT transmitter pulse generator: turns sync/data/pause commands into tick-accurate
// low/high pulses, tracking accumulated frame ticks so the pause can pad the frame.
module sent_tx_pulse_gen_p #(
   parameter int LOW_TICKS   = 5,
   parameter int SYNC_TICKS  = 56,
   parameter int NIBBLE_BASE = 12,
   parameter int NIBBLE_W    = 4,
   parameter int PAUSE_MODE  = 0,
   parameter int FRAME_TICKS = 250,
   parameter int PAUSE_TICKS = 77,
   parameter int PAUSE_MIN   = 12,
   parameter int CNT_W       = 10
) (
   input  logic                ticks,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_type,
   input  logic [NIBBLE_W-1:0] data_nibble,
   output logic                data_pulse,
   output logic                pulse_done,
   output logic                busy,
   output logic                pause_err,
   output logic                cmd_err,
   output logic [CNT_W-1:0]    frame_ticks
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE_L     = CNT_W'(1);
   localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_TICKS - 1);
   localparam logic [CNT_W-1:0] SYNC_L    = CNT_W'(SYNC_TICKS);
   localparam logic [CNT_W-1:0] BASE_L    = CNT_W'(NIBBLE_BASE);
   localparam logic [CNT_W-1:0] FRAME_L   = CNT_W'(FRAME_TICKS);
   localparam logic [CNT_W-1:0] PTICK_L   = CNT_W'(PAUSE_TICKS);
   localparam logic [CNT_W-1:0] PMIN_L    = CNT_W'(PAUSE_MIN);
   localparam logic [CNT_W-1:0] PAD_LIMIT = CNT_W'(FRAME_TICKS - PAUSE_MIN);

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [CNT_W-1:0] len_r, len_s;
   logic [CNT_W-1:0] frame_r, frame_s;
   logic             dp_r, dp_s;
   logic             done_r, done_s;
   logic             busy_r, busy_s;
   logic             perr_r, perr_s;
   logic             cerr_r, cerr_s;
   logic [CNT_W-1:0] cmd_len_s;
   logic             clamp_s;
   logic             last_s;
   logic             ready_s;
   logic             accept_s;
   logic             start_s;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // Handshake: ready in idle or on the last tick of a pulse so pulses chain seamlessly.
   always_comb begin
      last_s   = (state_r == ST_HIGH) && (cnt_r == (len_r - ONE_L));
      ready_s  = (state_r == ST_IDLE) || last_s;
      accept_s = cmd_valid && ready_s;
      start_s  = accept_s && (cmd_type != 2'b11);
   end

   // Pulse length decode for the command on the bus.
   always_comb begin
      cmd_len_s = '0;
      clamp_s   = 1'b0;
      case (cmd_type)
         2'b00: cmd_len_s = SYNC_L;
         2'b01: cmd_len_s = BASE_L + CNT_W'(data_nibble);
         2'b10: begin
            if (PAUSE_MODE != 0) begin
               cmd_len_s = PTICK_L;
            end else if (frame_r > PAD_LIMIT) begin
               cmd_len_s = PMIN_L;
               clamp_s   = 1'b1;
            end else begin
               cmd_len_s = FRAME_L - frame_r;
            end
         end
         default: cmd_len_s = '0;
      endcase
   end

   // Next-state, counters, frame accumulator and next register values of all outputs.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      len_s   = len_r;
      frame_s = frame_r;
      perr_s  = 1'b0;
      cerr_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_s = ST_LOW;
               cnt_s   = '0;
               len_s   = cmd_len_s;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOW: begin
            cnt_s = cnt_r + ONE_L;
            if (cnt_r == LOW_LAST) begin
               state_s = ST_HIGH;
            end else begin
               state_s = ST_LOW;
            end
         end
         ST_HIGH: begin
            if (last_s && start_s) begin
               state_s = ST_LOW;
               cnt_s   = '0;
               len_s   = cmd_len_s;
            end else if (last_s) begin
               state_s = ST_IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + ONE_L;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
         end
      endcase

      if (accept_s) begin
         case (cmd_type)
            2'b00, 2'b01: frame_s = sat_add(frame_r, cmd_len_s);
            2'b10: begin
               frame_s = '0;
               perr_s  = clamp_s;
            end
            default: cerr_s = 1'b1;
         endcase
      end else begin
         frame_s = frame_r;
      end

      dp_s   = (state_s != ST_LOW);
      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_HIGH) && (cnt_s == (len_s - ONE_L));
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge ticks) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         len_r   <= '0;
         frame_r <= '0;
         dp_r    <= 1'b1;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         perr_r  <= 1'b0;
         cerr_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         len_r   <= len_s;
         frame_r <= frame_s;
         dp_r    <= dp_s;
         done_r  <= done_s;
         busy_r  <= busy_s;
         perr_r  <= perr_s;
         cerr_r  <= cerr_s;
      end
   end

   assign cmd_ready   = ready_s;
   assign data_pulse  = dp_r;
   assign pulse_done  = done_r;
   assign busy        = busy_r;
   assign pause_err   = perr_r;
   assign cmd_err     = cerr_r;
   assign frame_ticks = frame_r;

endmodule

// File: tb/tb_sent_tx_pulse_gen_p.sv
// Directed bench for sent_tx_pulse_gen_p: one instance in pad-to-frame pause mode and
// one in constant-pause mode share stimulus; sel chooses which one is checked.
module tb_sent_tx_pulse_gen_p;

   logic       ticks = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic [1:0] cmd_type;
   logic [3:0] data_nibble;
   logic       sel;

   logic       rdy0, dp0, done0, busy0, perr0, cerr0;
   logic       rdy1, dp1, done1, busy1, perr1, cerr1;
   logic [9:0] ft0, ft1;

   logic       o_rdy, o_dp, o_done, o_busy, o_perr, o_cerr;
   logic [9:0] o_ft;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 ticks = ~ticks;

   sent_tx_pulse_gen_p #(.PAUSE_MODE(0)) dut0 (
      .ticks(ticks), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
      .cmd_type(cmd_type), .data_nibble(data_nibble), .data_pulse(dp0),
      .pulse_done(done0), .busy(busy0), .pause_err(perr0), .cmd_err(cerr0),
      .frame_ticks(ft0)
   );

   sent_tx_pulse_gen_p #(.PAUSE_MODE(1), .PAUSE_TICKS(77)) dut1 (
      .ticks(ticks), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
      .cmd_type(cmd_type), .data_nibble(data_nibble), .data_pulse(dp1),
      .pulse_done(done1), .busy(busy1), .pause_err(perr1), .cmd_err(cerr1),
      .frame_ticks(ft1)
   );

   assign o_rdy  = sel ? rdy1  : rdy0;
   assign o_dp   = sel ? dp1   : dp0;
   assign o_done = sel ? done1 : done0;
   assign o_busy = sel ? busy1 : busy0;
   assign o_perr = sel ? perr1 : perr0;
   assign o_cerr = sel ? cerr1 : cerr0;
   assign o_ft   = sel ? ft1   : ft0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ticks);
      #1;
   endtask

   // Present a command from idle and take it on the next edge; returns at tick 1.
   task automatic start(input logic [1:0] t, input logic [3:0] n, input string tag);
      chk({tag, " ready"}, o_rdy, 1);
      cmd_valid   = 1'b1;
      cmd_type    = t;
      data_nibble = n;
      step();
      cmd_valid = 1'b0;
   endtask

   // Check one pulse from tick 1 to tick exp_l; optionally chain the next command at tick L.
   task automatic run_pulse(input int exp_l, input logic nv, input logic [1:0] nt,
                            input logic [3:0] nn, input string tag);
      for (int k = 1; k <= exp_l; k++) begin
         chk($sformatf("%s k=%0d dp", tag, k), o_dp, (k <= 5) ? 0 : 1);
         chk($sformatf("%s k=%0d busy", tag, k), o_busy, 1);
         chk($sformatf("%s k=%0d done", tag, k), o_done, (k == exp_l) ? 1 : 0);
         chk($sformatf("%s k=%0d ready", tag, k), o_rdy, (k == exp_l) ? 1 : 0);
         if (k >= 2) begin
            chk($sformatf("%s k=%0d perr", tag, k), o_perr, 0);
            chk($sformatf("%s k=%0d cerr", tag, k), o_cerr, 0);
         end
         if (k == 2) data_nibble = 4'hA;
         if (k == exp_l && nv) begin
            cmd_valid   = 1'b1;
            cmd_type    = nt;
            data_nibble = nn;
         end
         step();
      end
      cmd_valid = 1'b0;
      if (!nv) begin
         chk({tag, " idle dp"}, o_dp, 1);
         chk({tag, " idle busy"}, o_busy, 0);
         chk({tag, " idle done"}, o_done, 0);
      end
   endtask

   initial begin
      sel         = 1'b0;
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_type    = 2'b00;
      data_nibble = 4'h0;
      repeat (3) @(posedge ticks);
      #1;
      reset = 1'b0;

      chk("rst dp", o_dp, 1);
      chk("rst done", o_done, 0);
      chk("rst busy", o_busy, 0);
      chk("rst perr", o_perr, 0);
      chk("rst cerr", o_cerr, 0);
      chk("rst ft", o_ft, 0);
      chk("rst ready", o_rdy, 1);

      // Sync pulse: 5 low, 51 high.
      start(2'b00, 4'h0, "sync");
      chk("sync ft", o_ft, 56);
      run_pulse(56, 1'b0, 2'b00, 4'h0, "sync");

      // Nibble 0 then nibble F, back-to-back.
      start(2'b01, 4'h0, "d0");
      chk("d0 ft", o_ft, 68);
      run_pulse(12, 1'b1, 2'b01, 4'hF, "d0");
      chk("dF ft", o_ft, 95);
      run_pulse(27, 1'b0, 2'b00, 4'h0, "dF");

      // Pause pads 95 up to 250.
      start(2'b10, 4'h0, "pad155");
      chk("pad155 ft", o_ft, 0);
      chk("pad155 perr", o_perr, 0);
      run_pulse(155, 1'b0, 2'b00, 4'h0, "pad155");

      // Sync + six zero nibbles = 128, pause of 122.
      start(2'b00, 4'h0, "f6");
      run_pulse(56, 1'b1, 2'b01, 4'h0, "f6 sync");
      for (int i = 0; i < 5; i++) run_pulse(12, 1'b1, 2'b01, 4'h0, "f6 nib");
      chk("f6 ft", o_ft, 128);
      run_pulse(12, 1'b1, 2'b10, 4'h0, "f6 nib");
      chk("p122 ft", o_ft, 0);
      chk("p122 perr", o_perr, 0);
      run_pulse(122, 1'b0, 2'b00, 4'h0, "p122");

      // Sync + eight F nibbles = 272, pause clamps to 12.
      start(2'b00, 4'h0, "f8");
      run_pulse(56, 1'b1, 2'b01, 4'hF, "f8 sync");
      for (int i = 0; i < 7; i++) run_pulse(27, 1'b1, 2'b01, 4'hF, "f8 nib");
      chk("f8 ft", o_ft, 272);
      run_pulse(27, 1'b1, 2'b10, 4'h0, "f8 nib");
      chk("p12 ft", o_ft, 0);
      chk("p12 perr", o_perr, 1);
      run_pulse(12, 1'b0, 2'b00, 4'h0, "p12");

      // Reserved command: error strobe, no pulse.
      start(2'b11, 4'h0, "rsv");
      chk("rsv cerr", o_cerr, 1);
      chk("rsv dp", o_dp, 1);
      chk("rsv busy", o_busy, 0);
      chk("rsv ready", o_rdy, 1);
      chk("rsv ft", o_ft, 0);
      step();
      chk("rsv cerr2", o_cerr, 0);
      chk("rsv dp2", o_dp, 1);

      // Reset at tick 20 of a sync pulse.
      start(2'b00, 4'h0, "abort");
      repeat (19) step();
      chk("abort t20 dp", o_dp, 1);
      chk("abort t20 busy", o_busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort dp", o_dp, 1);
      chk("abort busy", o_busy, 0);
      chk("abort ft", o_ft, 0);
      chk("abort ready", o_rdy, 1);
      start(2'b01, 4'h3, "d3");
      chk("d3 ft", o_ft, 15);
      run_pulse(15, 1'b0, 2'b00, 4'h0, "d3");

      // Constant-pause instance.
      sel   = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("m1 rst ft", o_ft, 0);
      start(2'b00, 4'h0, "m1");
      run_pulse(56, 1'b1, 2'b01, 4'h5, "m1 sync");
      chk("m1 ft", o_ft, 73);
      run_pulse(17, 1'b1, 2'b10, 4'h0, "m1 d5");
      chk("m1 pause ft", o_ft, 0);
      chk("m1 pause perr", o_perr, 0);
      run_pulse(77, 1'b0, 2'b00, 4'h0, "m1 pause");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
